// File: rtl/mc_pkg.sv
// Shared types for the memory-controller request front end.
// Opcodes, staging states and the default request bundle.
package mc_pkg;

    localparam int MC_ADDR_W = 36;
    localparam int MC_OP_W   = 2;
    localparam int MC_TIME_W = 32;

    typedef enum logic [1:0] {
        READ    = 2'd0,
        WRITE   = 2'd1,
        IFETCH  = 2'd2,
        ILLEGAL = 2'd3
    } memop_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STALL
    } stage_state_e;

    typedef struct packed {
        logic [MC_TIME_W-1:0] stamp;
        memop_e               op;
        logic [MC_ADDR_W-1:0] addr;
    } mc_req_t;

endpackage

// File: rtl/mc_request_queue_if.sv
// Request-in / request-out handshake bundle of the queue.
// master drives requests and pops; slave is the queue.
interface mc_request_queue_if #(
    parameter int ADDR_WIDTH  = 36,
    parameter int MEMOP_WIDTH = 2,
    parameter int TIME_WIDTH  = 32
);

    logic                   in_valid;
    logic                   in_ready;
    logic [TIME_WIDTH-1:0]  in_time;
    logic [MEMOP_WIDTH-1:0] in_op;
    logic [ADDR_WIDTH-1:0]  in_addr;

    logic                   out_valid;
    logic                   out_ready;
    logic [TIME_WIDTH-1:0]  out_time;
    logic [MEMOP_WIDTH-1:0] out_op;
    logic [ADDR_WIDTH-1:0]  out_addr;

    modport master (
        output in_valid, in_time, in_op, in_addr, out_ready,
        input  in_ready, out_valid, out_time, out_op, out_addr
    );

    modport slave (
        input  in_valid, in_time, in_op, in_addr, out_ready,
        output in_ready, out_valid, out_time, out_op, out_addr
    );

endinterface

// File: rtl/mc_sync_fifo.sv
// Show-ahead synchronous FIFO modelling the controller input queue.
// Full comes from the registered count, so a pop never frees a slot early.
module mc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Storage write; contents are masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mc_request_queue.sv
// Time-gated staging of trace requests into the controller queue.
// Holds one request until the cycle counter reaches its stamp.
module mc_request_queue
    import mc_pkg::*;
#(
    parameter int ADDR_WIDTH   = 36,
    parameter int MEMOP_WIDTH  = 2,
    parameter int TIME_WIDTH   = 32,
    parameter int IN_BUFF_CT   = 16,
    parameter int FAST_FORWARD = 1,
    localparam int CW          = $clog2(IN_BUFF_CT) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mc_request_queue_if.slave     bus,
    output logic [TIME_WIDTH-1:0] cycle_now,
    output logic [CW-1:0]         occupancy,
    output logic                  err_time_order,
    output logic                  err_illegal_op
);

    typedef struct packed {
        logic [TIME_WIDTH-1:0]  stamp;
        logic [MEMOP_WIDTH-1:0] op;
        logic [ADDR_WIDTH-1:0]  addr;
    } req_t;

    stage_state_e          state;
    req_t                  stg;
    req_t                  head;
    logic [TIME_WIDTH-1:0] last_time;
    logic                  full;
    logic                  empty;
    logic                  reached;
    logic                  push;
    logic                  pop;
    logic                  in_fire;
    logic                  illegal;

    assign reached = (cycle_now >= stg.stamp);
    assign push    = !full && ((state == WAIT && reached) || state == STALL);
    assign pop     = bus.out_valid && bus.out_ready;
    assign in_fire = bus.in_valid && (state == IDLE);
    assign illegal = (bus.in_op == MEMOP_WIDTH'(ILLEGAL));

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = !empty;
    assign bus.out_time  = head.stamp;
    assign bus.out_op    = head.op;
    assign bus.out_addr  = head.addr;

    mc_sync_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (IN_BUFF_CT)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (stg),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (occupancy)
    );

    // Staging FSM: capture, wait for the stamp, stall on a full queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            stg            <= '0;
            last_time      <= '0;
            err_time_order <= 1'b0;
            err_illegal_op <= 1'b0;
        end else begin
            err_time_order <= 1'b0;
            err_illegal_op <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_fire && illegal) begin
                        err_illegal_op <= 1'b1;
                    end else if (in_fire) begin
                        stg            <= '{bus.in_time, bus.in_op, bus.in_addr};
                        last_time      <= bus.in_time;
                        err_time_order <= (bus.in_time < last_time);
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    if (reached) state <= full ? STALL : IDLE;
                end
                STALL: begin
                    if (!full) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Cycle counter; jumps to the stamp when nothing is queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_now <= '0;
        end else if (FAST_FORWARD != 0 && state == WAIT &&
                     occupancy == '0 && !reached) begin
            cycle_now <= stg.stamp;
        end else if (cycle_now != '1) begin
            cycle_now <= cycle_now + 1'b1;
        end
    end

endmodule

// File: tb/tb_mc_request_queue.sv
// Directed bench for mc_request_queue with a release-order scoreboard.
// dut0 runs without fast-forward, dut1 with it.
module tb_mc_request_queue;
    import mc_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_request_queue_if #(.ADDR_WIDTH(36), .MEMOP_WIDTH(2), .TIME_WIDTH(32)) a ();
    mc_request_queue_if #(.ADDR_WIDTH(36), .MEMOP_WIDTH(2), .TIME_WIDTH(32)) b ();

    logic [31:0] cyc0, cyc1;
    logic [4:0]  occ0, occ1;
    logic        eto0, eio0, eto1, eio1;

    mc_request_queue #(.FAST_FORWARD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(a), .cycle_now(cyc0),
        .occupancy(occ0), .err_time_order(eto0), .err_illegal_op(eio0)
    );

    mc_request_queue #(.FAST_FORWARD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b), .cycle_now(cyc1),
        .occupancy(occ1), .err_time_order(eto1), .err_illegal_op(eio1)
    );

    int checks = 0;
    int failures = 0;
    mc_req_t q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; pops on dut0 are checked against the scoreboard first.
    task automatic cyc();
        mc_req_t e;
        if (a.out_valid && a.out_ready) begin
            if (q.size() == 0) begin
                chk("sb_extra_pop", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                chk("sb_time", a.out_time, e.stamp);
                chk("sb_op", a.out_op, e.op);
                chk("sb_addr", a.out_addr, e.addr);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] t, input logic [1:0] op, input logic [35:0] ad);
        mc_req_t e;
        int n = 0;
        while (!a.in_ready && n < 200) begin
            cyc();
            n++;
        end
        chk("send_in_ready", a.in_ready, 1);
        a.in_valid = 1'b1;
        a.in_time  = t;
        a.in_op    = op;
        a.in_addr  = ad;
        if (op != 2'd3) begin
            e.stamp = t;
            e.op    = memop_e'(op);
            e.addr  = ad;
            q.push_back(e);
        end
        cyc();
        a.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            cyc();
            n++;
        end
        chk("drain_left", q.size(), 0);
        chk("drain_occ", occ0, 0);
    endtask

    initial begin
        int n;
        a.in_valid = 0; a.in_time = 0; a.in_op = 0; a.in_addr = 0; a.out_ready = 0;
        b.in_valid = 0; b.in_time = 0; b.in_op = 0; b.in_addr = 0; b.out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_occ", occ0, 0);
        chk("rst_in_ready", a.in_ready, 1);
        chk("rst_out_valid", a.out_valid, 0);
        chk("rst_cycle", cyc0, 0);
        chk("rst_out_addr", a.out_addr, 0);
        chk("rst_err", {eto0, eio0}, 0);
        rst_n = 1'b1;

        // time-gated release without fast-forward
        a.out_ready = 1'b1;
        cyc();
        send(32'd10, 2'd0, 36'h01FF97000);
        n = 0;
        while (!a.out_valid && n < 100) begin
            cyc();
            n++;
        end
        chk("tg_valid", a.out_valid, 1);
        chk("tg_cycle", cyc0, 11);
        chk("tg_addr", a.out_addr, 36'h01FF97000);
        drain();

        // fast-forward on dut1
        b.in_valid = 1'b1; b.in_time = 32'd1000; b.in_op = 2'd2; b.in_addr = 36'hABC;
        cyc();
        b.in_valid = 1'b0;
        chk("ff_busy", b.in_ready, 0);
        cyc();
        chk("ff_load", cyc1, 1000);
        chk("ff_not_yet", b.out_valid, 0);
        cyc();
        chk("ff_valid", b.out_valid, 1);
        chk("ff_time", b.out_time, 1000);
        chk("ff_op", b.out_op, 2);
        chk("ff_addr", b.out_addr, 36'hABC);
        chk("ff_after", cyc1, 1001);

        // illegal opcode dropped, next request accepted
        send(32'd20, 2'd3, 36'h5);
        chk("ill_pulse", eio0, 1);
        chk("ill_in_ready", a.in_ready, 1);
        chk("ill_occ", occ0, 0);
        cyc();
        chk("ill_clear", eio0, 0);
        chk("ill_no_out", a.out_valid, 0);
        send(32'd20, 2'd1, 36'h123);
        chk("legal_no_err", eio0, 0);
        chk("legal_busy", a.in_ready, 0);
        drain();

        // non-monotonic stamps flagged, order kept
        send(32'd50, 2'd0, 36'h50);
        chk("to_first", eto0, 0);
        send(32'd40, 2'd2, 36'h40);
        chk("to_pulse", eto0, 1);
        cyc();
        chk("to_clear", eto0, 0);
        drain();

        // fill the queue and stall the 17th request
        a.out_ready = 1'b0;
        for (int i = 0; i < 17; i++) send(32'd0, 2'd1, 36'(i + 256));
        cyc();
        cyc();
        chk("full_occ", occ0, 16);
        chk("full_stall", a.in_ready, 0);
        chk("full_head", a.out_addr, 36'h100);
        a.out_ready = 1'b1;
        cyc();
        a.out_ready = 1'b0;
        chk("pop_occ", occ0, 15);
        chk("pop_still_stall", a.in_ready, 0);
        cyc();
        chk("refill_occ", occ0, 16);
        chk("refill_ready", a.in_ready, 1);

        // asynchronous reset while stalled
        send(32'd0, 2'd0, 36'h999);
        cyc();
        chk("pre_rst_stall", a.in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ars_occ", occ0, 0);
        chk("ars_valid", a.out_valid, 0);
        chk("ars_cycle", cyc0, 0);
        chk("ars_ready", a.in_ready, 1);
        chk("ars_addr", a.out_addr, 0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
        chk("post_rst_ready", a.in_ready, 1);
        chk("post_rst_valid", a.out_valid, 0);
        chk("post_rst_occ", occ0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_request_queue.md
# mc_request_queue

Synthesizable, parametrised front end between the trace parser and the memory controller. It accepts decoded trace requests (CPU-cycle time, operation, address) through a valid/ready handshake and holds each one until the internal CPU-cycle counter reaches its time stamp. Released requests go into a FIFO modelling the controller's input queue, and the FIFO presents them to the controller with valid/ready. It also enforces trace rules: illegal opcodes are dropped and non-monotonic time stamps are flagged. An optional mode fast-forwards simulated time while the controller is idle.

## Interface
- ADDR_WIDTH, 36: request address width.
- MEMOP_WIDTH, 2: opcode width (0 = read, 1 = write, 2 = ifetch, 3 = illegal).
- TIME_WIDTH, 32: CPU-cycle time-stamp and counter width.
- IN_BUFF_CT, 16: FIFO depth; must be a power of two and at least 2.
- FAST_FORWARD, 1: 1 enables idle time skipping.
---
- clk, in, 1: single clock; all state on rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- in_valid, in, 1: parser presents a request.
- in_ready, out, 1: staging register free.
- in_time, in, TIME_WIDTH: request CPU-cycle time.
- in_op, in, MEMOP_WIDTH: opcode.
- in_addr, in, ADDR_WIDTH: address.
- out_valid, out, 1: FIFO non-empty.
- out_ready, in, 1: controller pops the head.
- out_time, out_op, out_addr, out: head entry fields.
- cycle_now, out, TIME_WIDTH: current CPU-cycle counter.
- occupancy, out, $clog2(IN_BUFF_CT)+1: FIFO entry count.
- err_time_order, out, 1: one-cycle pulse.
- err_illegal_op, out, 1: one-cycle pulse.

## Operation
- **Staging FSM states:** IDLE, WAIT, STALL.
  - `in_ready` = (state == IDLE).
  - IDLE → WAIT on in_valid && in_ready with a legal op. The request is captured and last_time is set to in_time.
  - An illegal op (3) is not captured. err_illegal_op pulses and the FSM stays in IDLE.
  - WAIT → IDLE when cycle_now >= staged time and the FIFO is not full. The request is pushed on that edge.
  - WAIT → STALL when the time is reached but the FIFO is full.
  - STALL → IDLE on the first edge the FIFO is not full. The request is pushed on that edge.
- **Time order:** on capture, if in_time < last_time, err_time_order pulses and the request is still processed normally.
- **Cycle counter:** +1 per clock, saturating at all-ones.
  - If FAST_FORWARD = 1, state == WAIT, occupancy == 0 and cycle_now < staged time, the counter loads the staged time instead of incrementing.
- **FIFO:** show-ahead with registered storage.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle leave occupancy unchanged.
  - "Full" is taken from the registered occupancy, so a same-cycle pop never lets a push into a full FIFO.
  - Pointers wrap modulo IN_BUFF_CT.
- **Reset:** asynchronous; all of the following are cleared immediately, including mid-stall:
  - state = IDLE, cycle_now = 0, last_time = 0;
  - occupancy = 0 and FIFO pointers = 0;
  - out_valid = 0, out_time/op/addr = 0;
  - both error pulses = 0, in_ready = 1.
  - A staged request is discarded.

## Timing
- Capture edge N → state WAIT at N+1.
- Earliest push is edge N+1 (time already reached) → out_valid at N+2.
- Minimum input-to-output latency is 2 cycles; input throughput is at most 1 request per 2 cycles.
- Error pulses are asserted for exactly the cycle after the capture/reject edge.
- A fast-forward load costs 1 cycle; the push follows on the next edge.
- Releases are strictly in acceptance order; no reordering.

## Structure
- Package `mc_pkg`:
  - `memop_e` enum (READ = 0, WRITE = 1, IFETCH = 2, ILLEGAL = 3);
  - `stage_state_e` enum (IDLE, WAIT, STALL);
  - packed struct `mc_req_t` {time, op, addr}.
- Sub-module `mc_sync_fifo`: parametrised by width and depth; provides push, pop, full, empty, count and show-ahead data.
- Top level contains the FSM, the cycle counter and the checks.

## Test plan
- **Time-gated release:** reset, then one request {time = 10, op = 0, addr = 0x01FF97000} at cycle 2, FAST_FORWARD = 0 → out_valid rises the cycle after cycle_now reaches 10; out_addr = 0x01FF97000.
- **Fast-forward:** FAST_FORWARD = 1, empty FIFO, request time = 1000 accepted at cycle 3 → cycle_now = 1000 at cycle 5; out_valid at cycle 6.
- **Full FIFO:** hold out_ready = 0 and send 17 requests with time = 0 → occupancy saturates at 16 with the 17th request in STALL and in_ready = 0. One pop → the 17th is pushed the next edge and occupancy returns to 16.
- **Illegal op:** request op = 3 → err_illegal_op pulses 1 cycle, nothing enters the FIFO, and the following op = 1 request is accepted normally.
- **Time order:** requests with time 50 then 40 → err_time_order pulses on the second; both are delivered in order 50, 40.
- **Reset mid-stall:** assert rst_n = 0 mid-stall with 16 entries → occupancy = 0, out_valid = 0 and cycle_now = 0 asynchronously; after release, in_ready = 1.
